mod16_rr_sched: RTL and testbench

Round-robin scheduler that shares one `Modulus_16_flopped` unit (2-cycle registered modulus, `a % b`, 16-bit) among `NREQ` requesters. Each cycle it grants at most one valid request, drives the operands to the shared unit, and tracks a tag for every in-flight operation. It returns each result, registered, to the requester that issued it. It sits between client blocks and the modulus datapath and is the only driver of that datapath's operand inputs.

---
 rtl/mod16_rr_sched.sv | 108 ++++++++++
 tb/tb_mod16_rr_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mod16_rr_sched.sv
// Round-robin scheduler sharing one 2-cycle registered 16-bit modulus unit among NREQ
// requesters; tags each in-flight operation and returns the registered result to its issuer.
module mod16_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 hold,
    output logic [15:0]          mod_a,
    output logic [15:0]          mod_b,
    input  logic [15:0]          mod_result,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_result,
    output logic                 rsp_dz,
    output logic                 idle
);

    localparam int unsigned TW = $clog2(NREQ);
    localparam logic [NREQ-1:0] OneHotLsb = NREQ'(1);

    logic [TW-1:0]          ptr_q, ptr_d;
    logic                   grant;
    logic [TW-1:0]          win;
    logic [TW:0]            cand;
    logic                   dz_in;

    logic [LAT-1:0]         pipe_vld_q;
    logic [LAT-1:0][TW-1:0] pipe_tag_q;
    logic [LAT-1:0]         pipe_dz_q;

    // Search from ptr_q upward, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (TW+1)'(k);
            if (cand >= (TW+1)'(NREQ)) begin
                cand = cand - (TW+1)'(NREQ);
            end
            if (!grant && req_valid[cand[TW-1:0]]) begin
                grant = 1'b1;
                win   = cand[TW-1:0];
            end
        end
        if (hold || !rst_n) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        req_ready = grant ? (OneHotLsb << win) : '0;
        ptr_d     = ptr_q;
        if (grant) begin
            ptr_d = (win == TW'(NREQ - 1)) ? '0 : win + TW'(1);
        end
    end

    always_comb begin
        mod_a = 16'h0;
        mod_b = 16'h0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (req_ready[i]) begin
                mod_a = req_a[16*i +: 16];
                mod_b = req_b[16*i +: 16];
            end
        end
        dz_in = (mod_b == 16'h0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            pipe_vld_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            pipe_vld_q <= {pipe_vld_q[LAT-2:0], grant};
        end
    end

    // Tag and divide-by-zero flag only matter alongside a set valid bit.
    always_ff @(posedge clk) begin
        pipe_tag_q <= {pipe_tag_q[LAT-2:0], win};
        pipe_dz_q  <= {pipe_dz_q[LAT-2:0], dz_in};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_result <= 16'h0;
            rsp_dz     <= 1'b0;
        end else if (pipe_vld_q[LAT-1]) begin
            rsp_valid  <= OneHotLsb << pipe_tag_q[LAT-1];
            rsp_result <= mod_result;
            rsp_dz     <= pipe_dz_q[LAT-1];
        end else begin
            rsp_valid  <= '0;
        end
    end

    assign idle = ~|pipe_vld_q & ~|req_ready & ~|rsp_valid;

endmodule

// File: tb/tb_mod16_rr_sched.sv
// Randomized and directed bench for mod16_rr_sched; a behavioural model predicts grants,
// operands, responses and idle every cycle, with a local stand-in for the modulus unit.
module tb_mod16_rr_sched;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               hold;
    logic [15:0]        mod_a;
    logic [15:0]        mod_b;
    logic [15:0]        mod_result;
    logic [NREQ-1:0]    rsp_valid;
    logic [15:0]        rsp_result;
    logic               rsp_dz;
    logic               idle;

    mod16_rr_sched #(
        .NREQ(NREQ),
        .LAT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .hold      (hold),
        .mod_a     (mod_a),
        .mod_b     (mod_b),
        .mod_result(mod_result),
        .rsp_valid (rsp_valid),
        .rsp_result(rsp_result),
        .rsp_dz    (rsp_dz),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // Stand-in for the 2-cycle flopped modulus unit; divide by zero yields all ones.
    logic [15:0] mod_s1, mod_s2;
    always @(posedge clk) begin
        mod_s1 <= (mod_b == 16'h0) ? 16'hFFFF : mod_a % mod_b;
        mod_s2 <= mod_s1;
    end
    assign mod_result = mod_s2;

    typedef struct {
        int          due;
        int          idx;
        logic [15:0] res;
        logic        dz;
    } exp_t;

    exp_t        exp_q[$];
    int          model_ptr = 0;
    int          cyc       = 0;
    logic [15:0] last_res  = 16'h0;
    logic        last_dz   = 1'b0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    // One clock cycle: drive, check mid-cycle against the model, then advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic [63:0] a, input logic [63:0] b,
                        input logic h, input logic rn);
        int          g;
        int          exp_ready;
        int          exp_rv;
        logic [15:0] exp_a, exp_b;
        logic        exp_idle;
        exp_t        e;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        hold      = h;
        rst_n     = rn;
        #4;
        g = -1;
        if (rn && !h) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && v[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
            end
        end
        exp_ready = 0;
        exp_a     = 16'h0;
        exp_b     = 16'h0;
        if (g >= 0) begin
            exp_ready = 1 << g;
            exp_a     = a[16*g +: 16];
            exp_b     = b[16*g +: 16];
        end
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("mod_a", mod_a, exp_a);
        check_eq("mod_b", mod_b, exp_b);
        exp_idle = (exp_q.size() == 0) && (g < 0);
        exp_rv   = 0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_rv   = 1 << exp_q[0].idx;
            last_res = exp_q[0].res;
            last_dz  = exp_q[0].dz;
            void'(exp_q.pop_front());
        end
        check_eq("rsp_valid", rsp_valid, exp_rv);
        check_eq("rsp_result", rsp_result, last_res);
        check_eq("rsp_dz", rsp_dz, last_dz);
        check_eq("idle", idle, exp_idle);
        @(posedge clk);
        if (!rn) begin
            model_ptr = 0;
            exp_q.delete();
            last_res  = 16'h0;
            last_dz   = 1'b0;
        end else if (g >= 0) begin
            e.due = cyc + 3;
            e.idx = g;
            e.dz  = (exp_b == 16'h0);
            e.res = e.dz ? 16'hFFFF : exp_a % exp_b;
            exp_q.push_back(e);
            model_ptr = (g + 1) % NREQ;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 64'h0, 64'h0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [63:0] ra, rb;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        hold      = 1'b0;
        @(posedge clk);
        #1;
        // Grants must stay suppressed while in reset.
        for (int i = 0; i < 3; i++) step(4'b1111, 64'h1, 64'h1, 1'b0, 1'b0);
        idle_cycles(2);

        // Single issue from requester 2: 100 % 7.
        step(4'b0100, pack4(0, 0, 100, 0), pack4(1, 1, 7, 1), 1'b0, 1'b1);
        idle_cycles(4);

        // Full contention from a reset pointer.
        step(4'b0000, 64'h0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, pack4(17, 65535, 9, 3), pack4(5, 256, 9, 10), 1'b0, 1'b1);
        end
        idle_cycles(4);

        // Pointer wrap: requester 3 first, then 0 beats 3.
        step(4'b0000, 64'h0, 64'h0, 1'b0, 1'b0);
        step(4'b1000, pack4(5, 0, 0, 50), pack4(3, 1, 1, 6), 1'b0, 1'b1);
        step(4'b1001, pack4(5, 0, 0, 50), pack4(3, 1, 1, 6), 1'b0, 1'b1);
        step(4'b1001, pack4(5, 0, 0, 50), pack4(3, 1, 1, 6), 1'b0, 1'b1);
        idle_cycles(4);

        // Hold with pending requests, then release into a same-cycle grant.
        step(4'b1111, pack4(40, 41, 42, 43), pack4(6, 7, 8, 9), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, pack4(40, 41, 42, 43), pack4(6, 7, 8, 9), 1'b1, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, pack4(40, 41, 42, 43), pack4(6, 7, 8, 9), 1'b0, 1'b1);
        end
        idle_cycles(4);

        // Divide by zero from requester 1, followed by a normal divisor.
        step(4'b0010, pack4(0, 77, 0, 0), pack4(1, 0, 1, 1), 1'b0, 1'b1);
        step(4'b0010, pack4(0, 77, 0, 0), pack4(1, 3, 1, 1), 1'b0, 1'b1);
        idle_cycles(4);

        // Reset with two operations in flight.
        step(4'b0001, pack4(1000, 0, 0, 0), pack4(33, 1, 1, 1), 1'b0, 1'b1);
        step(4'b0100, pack4(0, 0, 999, 0), pack4(1, 1, 10, 1), 1'b0, 1'b1);
        step(4'b0000, 64'h0, 64'h0, 1'b0, 1'b0);
        idle_cycles(3);
        step(4'b1001, pack4(8, 0, 0, 9), pack4(3, 1, 1, 4), 1'b0, 1'b1);
        idle_cycles(4);

        for (int n = 0; n < 600; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            for (int s = 0; s < NREQ; s++) begin
                case ($urandom_range(0, 9))
                    0:       rb[16*s +: 16] = 16'h0;
                    1, 2, 3: rb[16*s +: 16] = 16'($urandom_range(1, 20));
                    default: ;
                endcase
            end
            step(4'($urandom), ra, rb, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 49) != 0));
        end
        idle_cycles(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
